bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master bus arbiter that shares the single slave bus (memory at 0x0000–0x07FF, factorial core at 0x7000–0x703F) between master 0 (CPU-side testbench master) and master 1 (DMA-style master). It holds a registered grant per master, muxes the owning master's request, write, address and data onto the slave bus, and uses round-robin on contention. It sits between the masters and the existing address decoder/slave mux inside Top.

## Interface
- ADDR_W, 16, bus address width
- DATA_W, 64, bus data width
- MAX_HOLD, 16, max consecutive grant cycles while the other master waits (only with timeout feature); legal range 2–255
- clk  input  1  bus clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- m0_req, m1_req  input  1  master bus request
- m0_wr, m1_wr  input  1  1 = write, 0 = read
- m0_addr, m1_addr  input  ADDR_W  master address
- m0_dout, m1_dout  input  DATA_W  master write data
- m0_grant, m1_grant  output  1  registered grant, one-hot or both 0
- s_req  output  1  muxed request to decoder/slaves
- s_wr  output  1  muxed write strobe
- s_addr  output  ADDR_W  muxed address
- s_dout  output  DATA_W  muxed write data
- bus_owner  output  2  00 none, 01 master 0, 10 master 1

## Operation
- States: IDLE, GRANT0, GRANT1 (registered). Grants and bus_owner decoded from state.
- Register last_owner (1 bit) records most recent granted master; reset value 1, so master 0 wins the first tie.
- IDLE: both req -> grant master != last_owner; only m0_req -> GRANT0; only m1_req -> GRANT1; none -> IDLE.
- GRANTx: mx_req high -> stay (grant held for multi-cycle transfers, no preemption). mx_req low and other req high -> GRANT of other (direct handover, no IDLE cycle). Both low -> IDLE.
- On entry to GRANTx, last_owner <= x.
- Slave-side mux (combinational from state): GRANT0 drives m0_* onto s_*, GRANT1 drives m1_*; s_req = owner's req. IDLE drives s_req=0, s_wr=0, s_addr=0, s_dout=0.
- Non-owner's inputs never reach s_*; a non-owner's write cannot occur.
- m_din read return is broadcast by Top unchanged; masters qualify it with their own grant.

## Timing
- Reset: state IDLE, m0_grant=0, m1_grant=0, bus_owner=00, s_req=0, s_wr=0, s_addr=0, s_dout=0, last_owner=1, hold counter 0.
- Request-to-grant latency: 1 cycle (req sampled at edge N, grant visible after edge N).
- Grant release: owner drops req at edge N -> grant falls after edge N; the other master's grant rises on that same edge if it was requesting.
- Owner's first slave access is the cycle its grant is high; s_* follow owner inputs combinationally within the cycle.
- Simultaneous req from IDLE: round-robin via last_owner; alternates on repeated ties.
- reset asserted mid-grant: next edge returns to IDLE and all reset values regardless of req.

## Configuration
- Macro BUS_ARB_TIMEOUT_EN.
- Defined: 8-bit hold counter cleared on every state change, incremented each cycle in GRANTx. When count == MAX_HOLD-1 and the other master requests, next state is GRANT of other even if owner req still high (owner loses grant for at least one arbitration round). Counter saturates if no other requester.
- Undefined: no counter; owner holds the bus indefinitely while req is high; MAX_HOLD ignored.

## Structure
- Shared package bus_pkg: state encoding (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10), bus_owner codes, ADDR_W/DATA_W defaults, slave address map constants (MEM_BASE 0x0000, MEM_LAST 0x07FF, FACT_BASE 0x7000, FACT_LAST 0x703F).
- One sub-module natural: bus_mux (combinational owner-select of req/wr/addr/dout); FSM, last_owner and counter stay in bus_arbiter.

## Test plan
- Reset: hold reset 2 cycles with both req high -> all grants 0, s_* all 0, bus_owner 00; first edge after release grants master 0.
- Single master: m1_req=1, m1_wr=1, m1_addr=0x006F, m1_dout=0x3333_3333_3333_3333 -> m1_grant=1 one cycle later, s_addr=0x006F, s_dout matches, memory readback from master 0 returns same value.
- Contention round-robin: both req held, each drops req after 3 cycles then re-asserts -> grant sequence 0,1,0,1 with direct handover, no IDLE cycle.
- Hold without preemption (macro undefined): m0 holds req 40 cycles programming factorial (0x7020=8, 0x7000=1) while m1 requests -> m1_grant stays 0 for all 40 cycles, then rises on the release edge.
- Timeout (BUS_ARB_TIMEOUT_EN, MAX_HOLD=4): m0 holds req, m1 requests -> m0_grant drops after 4 grant cycles, m1_grant rises same edge; m0 re-granted after m1 releases.
- Reset mid-grant: m1 owning a write to 0x7018 -> reset for 1 cycle forces IDLE, s_req=0, no write reaches the slave after that edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter: state encoding,
// bus_owner codes, default bus widths and the slave address map.
package bus_pkg;

  localparam int unsigned AddrWDefault = 16;
  localparam int unsigned DataWDefault = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrant0 = 2'b01,
    StGrant1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] OwnerNone = 2'b00;
  localparam logic [1:0] OwnerM0   = 2'b01;
  localparam logic [1:0] OwnerM1   = 2'b10;

  localparam logic [15:0] MEM_BASE  = 16'h0000;
  localparam logic [15:0] MEM_LAST  = 16'h07FF;
  localparam logic [15:0] FACT_BASE = 16'h7000;
  localparam logic [15:0] FACT_LAST = 16'h703F;

  function automatic logic [1:0] owner_code(arb_state_e st);
    logic [1:0] code;
    code = OwnerNone;
    unique case (st)
      StGrant0: code = OwnerM0;
      StGrant1: code = OwnerM1;
      default:  code = OwnerNone;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of master-side request signals and slave-side muxed bus for bus_arbiter.
// master: the requesting side; slave: the arbiter's view.
interface bus_arbiter_if import bus_pkg::*; #(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
);

  logic              m0_req;
  logic              m1_req;
  logic              m0_wr;
  logic              m1_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_dout;
  logic [DATA_W-1:0] m1_dout;

  logic              m0_grant;
  logic              m1_grant;
  logic              s_req;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_dout;
  logic [1:0]        bus_owner;

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
    input  m0_grant, m1_grant, s_req, s_wr, s_addr, s_dout, bus_owner
  );

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout,
    output m0_grant, m1_grant, s_req, s_wr, s_addr, s_dout, bus_owner
  );

endinterface

// File: rtl/bus_mux.sv
// Combinational owner-select of req/wr/addr/dout onto the slave bus.
// With no owner the slave bus is driven to all zeros.
module bus_mux import bus_pkg::*; #(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  arb_state_e        state_i,
  input  logic              m0_req_i,
  input  logic              m0_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_dout_i,
  input  logic              m1_req_i,
  input  logic              m1_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_dout_i,
  output logic              s_req_o,
  output logic              s_wr_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_dout_o
);

  always_comb begin
    s_req_o  = 1'b0;
    s_wr_o   = 1'b0;
    s_addr_o = '0;
    s_dout_o = '0;
    unique case (state_i)
      StGrant0: begin
        s_req_o  = m0_req_i;
        s_wr_o   = m0_wr_i;
        s_addr_o = m0_addr_i;
        s_dout_o = m0_dout_i;
      end
      StGrant1: begin
        s_req_o  = m1_req_i;
        s_wr_o   = m1_wr_i;
        s_addr_o = m1_addr_i;
        s_dout_o = m1_dout_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with registered grants and owner-select mux.
// Optional hold timeout enabled by defining BUS_ARB_TIMEOUT_EN (uses MAX_HOLD).
module bus_arbiter import bus_pkg::*; #(
  parameter int unsigned ADDR_W   = AddrWDefault,
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  // 0: master 0 was granted last, 1: master 1 was granted last.
  logic       last_owner_q, last_owner_d;
  logic       timeout_hit;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  assign timeout_hit = (hold_q == HoldLast);

  // Saturating at HoldLast keeps the preemption armed until the other master asks.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = '0;
    end else if (state_q != StIdle && !timeout_hit) begin
      hold_d = hold_q + 8'd1;
    end
  end
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign timeout_hit     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m0_req && bus.m1_req) begin
          state_d = last_owner_q ? StGrant0 : StGrant1;
        end else if (bus.m0_req) begin
          state_d = StGrant0;
        end else if (bus.m1_req) begin
          state_d = StGrant1;
        end
      end
      StGrant0: begin
        if (bus.m0_req && !(timeout_hit && bus.m1_req)) begin
          state_d = StGrant0;
        end else if (bus.m1_req) begin
          state_d = StGrant1;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant1: begin
        if (bus.m1_req && !(timeout_hit && bus.m0_req)) begin
          state_d = StGrant1;
        end else if (bus.m0_req) begin
          state_d = StGrant0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StGrant0) begin
      last_owner_d = 1'b0;
    end else if (state_d == StGrant1) begin
      last_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign bus.m0_grant  = (state_q == StGrant0);
  assign bus.m1_grant  = (state_q == StGrant1);
  assign bus.bus_owner = owner_code(state_q);

  bus_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus_mux (
    .state_i   (state_q),
    .m0_req_i  (bus.m0_req),
    .m0_wr_i   (bus.m0_wr),
    .m0_addr_i (bus.m0_addr),
    .m0_dout_i (bus.m0_dout),
    .m1_req_i  (bus.m1_req),
    .m1_wr_i   (bus.m1_wr),
    .m1_addr_i (bus.m1_addr),
    .m1_dout_i (bus.m1_dout),
    .s_req_o   (bus.s_req),
    .s_wr_o    (bus.s_wr),
    .s_addr_o  (bus.s_addr),
    .s_dout_o  (bus.s_dout)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected bus state computed
// from an abstract owner/round-robin model; a negedge monitor pops and compares.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 64;
  localparam int unsigned MaxHold = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  typedef struct {
    logic          g0;
    logic          g1;
    logic [1:0]    own;
    logic          sreq;
    logic          swr;
    logic [AW-1:0] saddr;
    logic [DW-1:0] sdout;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model: owner is -1 (none), 0 or 1; held counts grant cycles incl. current.
  int owner = -1;
  int last  = 1;
  int held  = 0;

  task automatic model_step(input logic rst, input logic r0, input logic r1);
    int nxt;
    logic mine, other;
    if (rst) begin
      owner = -1;
      last  = 1;
      held  = 0;
      return;
    end
    if (owner < 0) begin
      if (r0 && r1) nxt = 1 - last;
      else if (r0)  nxt = 0;
      else if (r1)  nxt = 1;
      else          nxt = -1;
    end else begin
      mine  = (owner == 0) ? r0 : r1;
      other = (owner == 0) ? r1 : r0;
      if (mine && !(TimeoutOn && other && held >= int'(MaxHold))) nxt = owner;
      else if (other) nxt = 1 - owner;
      else            nxt = -1;
    end
    if (nxt < 0)           held = 0;
    else if (nxt == owner) held = held + 1;
    else                   held = 1;
    if (nxt >= 0) last = nxt;
    owner = nxt;
  endtask

  task automatic cycle(input logic rst,
                       input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1);
    exp_t e;
    @(posedge clk);
    model_step(reset, bus.m0_req, bus.m1_req);
    #1;
    reset       = rst;
    bus.m0_req  = r0;
    bus.m0_wr   = w0;
    bus.m0_addr = a0;
    bus.m0_dout = d0;
    bus.m1_req  = r1;
    bus.m1_wr   = w1;
    bus.m1_addr = a1;
    bus.m1_dout = d1;
    e.g0    = (owner == 0);
    e.g1    = (owner == 1);
    e.own   = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    e.sreq  = 1'b0;
    e.swr   = 1'b0;
    e.saddr = '0;
    e.sdout = '0;
    if (owner == 0) begin
      e.sreq = r0; e.swr = w0; e.saddr = a0; e.sdout = d0;
    end else if (owner == 1) begin
      e.sreq = r1; e.swr = w1; e.saddr = a1; e.sdout = d1;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0)
      return AW'(MEM_BASE + 16'($urandom_range(0, int'(MEM_LAST - MEM_BASE))));
    return AW'(FACT_BASE + 16'($urandom_range(0, int'(FACT_LAST - FACT_BASE))));
  endfunction

  task automatic rnd_cycle(input logic rst, input logic r0, input logic r1);
    cycle(rst, r0, 1'($urandom), rnd_addr(), {$urandom, $urandom},
               r1, 1'($urandom), rnd_addr(), {$urandom, $urandom});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.m0_grant !== e.g0 || bus.m1_grant !== e.g1 || bus.bus_owner !== e.own ||
          bus.s_req !== e.sreq || bus.s_wr !== e.swr || bus.s_addr !== e.saddr ||
          bus.s_dout !== e.sdout) begin
        n_fail++;
        $display("FAIL cyc%0d bus_state got g=%b%b own=%b req=%b wr=%b addr=%h dout=%h exp g=%b%b own=%b req=%b wr=%b addr=%h dout=%h",
                 cyc, bus.m0_grant, bus.m1_grant, bus.bus_owner, bus.s_req, bus.s_wr,
                 bus.s_addr, bus.s_dout, e.g0, e.g1, e.own, e.sreq, e.swr, e.saddr,
                 e.sdout);
      end
    end
  end

  initial begin : stimulus
    logic r0, r1;
    reset       = 1'b1;
    bus.m0_req  = 1'b1;
    bus.m1_req  = 1'b1;
    bus.m0_wr   = 1'b0;
    bus.m1_wr   = 1'b0;
    bus.m0_addr = '0;
    bus.m1_addr = '0;
    bus.m0_dout = '0;
    bus.m1_dout = '0;

    // Reset held two cycles with both requesting, then master 0 wins the first tie.
    repeat (2) rnd_cycle(1'b1, 1'b1, 1'b1);
    repeat (3) rnd_cycle(1'b0, 1'b1, 1'b1);
    rnd_cycle(1'b0, 1'b0, 1'b0);
    rnd_cycle(1'b0, 1'b0, 1'b0);

    // Single master 1 write.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, '0,
                     1'b1, 1'b1, 16'h006F, 64'h3333_3333_3333_3333);
    rnd_cycle(1'b0, 1'b0, 1'b0);

    // Contention: owner drops for one cycle after three cycles with both asking.
    for (int k = 0; k < 4; k++) begin
      repeat (3) rnd_cycle(1'b0, 1'b1, 1'b1);
      if (owner == 0) rnd_cycle(1'b0, 1'b0, 1'b1);
      else            rnd_cycle(1'b0, 1'b1, 1'b0);
    end
    rnd_cycle(1'b0, 1'b0, 1'b0);
    rnd_cycle(1'b0, 1'b0, 1'b0);

    // Master 0 programs the factorial core for 40 cycles while master 1 waits.
    cycle(1'b0, 1'b1, 1'b1, 16'h7020, 64'd8, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1, 1'b1, (k < 20) ? 16'h7020 : 16'h7000, (k < 20) ? 64'd8 : 64'd1,
            1'b1, 1'b0, 16'h0010, 64'hABCD);
    end
    repeat (4) rnd_cycle(1'b0, 1'b0, 1'b1);
    repeat (2) rnd_cycle(1'b0, 1'b0, 1'b0);

    // Reset while master 1 owns a write to the factorial core.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h7018, 64'h55);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h7018, 64'h55);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h7018, 64'h55);

    // Random sticky requests with occasional reset pulses.
    r0 = 1'b0;
    r1 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      rnd_cycle(($urandom_range(0, 63) == 0), r0, r1);
    end
    rnd_cycle(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
